// File: rtl/des_iter_core.sv
// Iterative DES engine: one Feistel round per clock, 17 cycles from accepted start to done.
// The key schedule rotates C/D in place, left for encrypt and right for decrypt.
module des_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic [63:0] din,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout
);

  // Tables use DES bit numbering: entry value n means source bit n, where bit 1 is the MSB.
  localparam int unsigned IpTab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FpTab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned ETab [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int unsigned PTab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // S1..S8 concatenated; each box is 4 rows of 16 columns.
  localparam int unsigned SBoxTab [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] res;
    for (int i = 0; i < 64; i++) res[6'(63 - i)] = x[6'(64 - IpTab[i])];
    return res;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] res;
    for (int i = 0; i < 64; i++) res[6'(63 - i)] = x[6'(64 - FpTab[i])];
    return res;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] res;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = x[5'(32 - ETab[i])];
    return res;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] res;
    for (int i = 0; i < 32; i++) res[5'(31 - i)] = x[5'(32 - PTab[i])];
    return res;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] res;
    for (int i = 0; i < 56; i++) res[6'(55 - i)] = x[6'(64 - Pc1Tab[i])];
    return res;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] res;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = x[6'(56 - Pc2Tab[i])];
    return res;
  endfunction

  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [31:0] res;
    logic [5:0]  six;
    for (int n = 0; n < 8; n++) begin
      six = x[6'(47 - 6 * n) -: 6];
      res[5'(31 - 4 * n) -: 4] = 4'(SBoxTab[{3'(n), six[5], six[0], six[4:1]}]);
    end
    return res;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                        input logic right);
    logic [27:0] res;
    res = x;
    if (right) begin
      if (amt == 2'd1)      res = {x[0], x[27:1]};
      else if (amt == 2'd2) res = {x[1:0], x[27:2]};
    end else begin
      if (amt == 2'd1)      res = {x[26:0], x[27]};
      else if (amt == 2'd2) res = {x[25:0], x[27:26]};
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  cnt_q;
  logic        mode_q;
  logic [63:0] dout_q;

  logic        accept, last_round;
  logic [1:0]  shamt;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] r_next;

  assign accept     = start && (state_q != StRound);
  assign last_round = (state_q == StRound) && (cnt_q == 4'd15);

  // Decrypt round 1 uses the unrotated PC-1 halves, i.e. K16.
  always_comb begin
    shamt = 2'd2;
    if (cnt_q == 4'd0) begin
      shamt = mode_q ? 2'd0 : 2'd1;
    end else if (cnt_q == 4'd1 || cnt_q == 4'd8 || cnt_q == 4'd15) begin
      shamt = 2'd1;
    end
  end

  always_comb begin
    c_rot  = rot28(c_q, shamt, mode_q);
    d_rot  = rot28(d_q, shamt, mode_q);
    subkey = perm_pc2({c_rot, d_rot});
    r_next = l_q ^ perm_p(sbox_layer(expand(r_q) ^ subkey));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = start ? StRound : StIdle;
      StRound: state_d = last_round ? StDone : StRound;
      StDone:  state_d = start ? StRound : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRound);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      dout_q <= '0;
    end else if (accept) begin
      {l_q, r_q} <= perm_ip(din);
      {c_q, d_q} <= perm_pc1(key);
      mode_q     <= decrypt;
      cnt_q      <= '0;
    end else if (state_q == StRound) begin
      l_q <= r_q;
      r_q <= r_next;
      c_q <= c_rot;
      d_q <= d_rot;
      if (last_round) begin
        // Final swap: output is FP({R16, L16}) with L16 = R15.
        dout_q <= perm_fp({r_next, r_q});
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign dout = dout_q;

endmodule
